// File: rtl/probe_rx.sv
// probe_rx: XGMII probe-frame receiver. Validates IPv4/UDP probe headers, measures
// one-way latency against global_counter, and reports per-second frame/byte rates.
// Ports: sys_clk/sys_rst_n (async active-low); global_counter timestamp; xgmii_rxd/rxc
// receive lanes; rx_pps/rx_throughput per-second stats; rx_latency/rx_ipv4_ip of the
// last matched frame; rx_err_count saturating aborted/runt frame count.
module probe_rx #(
    parameter logic [31:0] Int_ipv4_addr = 32'h0A001569,
    parameter logic [31:0] Magic_code    = 32'h0,
    parameter logic [27:0] Sec_cycles    = 28'd156250000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] global_counter,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic [31:0] rx_pps,
    output logic [31:0] rx_throughput,
    output logic [23:0] rx_latency,
    output logic [31:0] rx_ipv4_ip,
    output logic [15:0] rx_err_count
);
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;
    state_t      state_q;
    logic [2:0]  idx_q;
    logic [12:0] wcnt_q;
    logic        mis_q;
    logic [15:0] ts_hi_q;
    logic [31:0] src_q;
    logic [23:0] lat_q;
    logic [31:0] acc_pps_q, acc_bytes_q;
    logic [27:0] sec_q;
    logic        is_start, term, abort, in_frame, tick, match, err_ev, word_bad;
    logic [2:0]  term_lane;
    logic [31:0] mid32, diff, bytes, acc_pps_d, acc_bytes_d;
    logic [15:0] hi16, lo16;
    logic [23:0] lat_d;
    logic [32:0] pps_sum, bytes_sum;
    // Lowest lane carrying FD marks the end of frame; FE in any lane aborts it.
    always_comb begin
        term      = 1'b0;
        abort     = 1'b0;
        term_lane = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (xgmii_rxc[i] && xgmii_rxd[8*i +: 8] == 8'hFD) begin
                term      = 1'b1;
                term_lane = 3'(i);
            end
            if (xgmii_rxc[i] && xgmii_rxd[8*i +: 8] == 8'hFE) abort = 1'b1;
        end
    end
    assign is_start = xgmii_rxc == 8'h01 && xgmii_rxd[7:0] == 8'hFB;
    assign in_frame = state_q != IDLE;
    assign tick     = sec_q == 28'd0;
    // Big-endian field views: lanes 2-5, lanes 6-7, lanes 0-1.
    assign mid32 = {xgmii_rxd[23:16], xgmii_rxd[31:24], xgmii_rxd[39:32], xgmii_rxd[47:40]};
    assign hi16  = {xgmii_rxd[55:48], xgmii_rxd[63:56]};
    assign lo16  = {xgmii_rxd[7:0], xgmii_rxd[15:8]};
    assign word_bad = (idx_q == 3'd2 && xgmii_rxd[63:32] != 32'h0045_0008) ||
                      (idx_q == 3'd3 && xgmii_rxd[63:56] != 8'h11) ||
                      (idx_q == 3'd4 && hi16 != Int_ipv4_addr[31:16]) ||
                      (idx_q == 3'd5 && lo16 != Int_ipv4_addr[15:0]) ||
                      (idx_q == 3'd6 && mid32 != Magic_code);
    assign diff  = global_counter - {ts_hi_q, lo16};
    assign lat_d = diff[31:24] == 8'd0 ? diff[23:0] : 24'hFFFFFF;
    // Word 0 holds preamble/SFD, so its 8 bytes are excluded from the frame length.
    assign bytes  = 32'({wcnt_q, 3'b000}) + 32'(term_lane) - 32'd8;
    assign match  = state_q == PAYLOAD && term && !abort && !mis_q;
    assign err_ev = in_frame && (is_start || abort || (term && state_q == HDR));
    assign pps_sum   = {1'b0, acc_pps_q} + 33'd1;
    assign bytes_sum = {1'b0, acc_bytes_q} + {1'b0, bytes};
    // A frame completing on the tick edge belongs to the new second.
    assign acc_pps_d   = tick ? (match ? 32'd1 : 32'd0) :
                         !match ? acc_pps_q : pps_sum[32] ? 32'hFFFFFFFF : pps_sum[31:0];
    assign acc_bytes_d = tick ? (match ? bytes : 32'd0) :
                         !match ? acc_bytes_q : bytes_sum[32] ? 32'hFFFFFFFF : bytes_sum[31:0];
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            idx_q         <= 3'd0;
            wcnt_q        <= 13'd0;
            mis_q         <= 1'b0;
            ts_hi_q       <= 16'd0;
            src_q         <= 32'd0;
            lat_q         <= 24'd0;
            acc_pps_q     <= 32'd0;
            acc_bytes_q   <= 32'd0;
            sec_q         <= Sec_cycles;
            rx_pps        <= 32'd0;
            rx_throughput <= 32'd0;
            rx_latency    <= 24'd0;
            rx_ipv4_ip    <= 32'd0;
            rx_err_count  <= 16'd0;
        end else begin
            sec_q       <= tick ? Sec_cycles : sec_q - 28'd1;
            acc_pps_q   <= acc_pps_d;
            acc_bytes_q <= acc_bytes_d;
            if (tick) begin
                rx_pps        <= acc_pps_q;
                rx_throughput <= acc_bytes_q;
            end
            if (match) begin
                rx_latency <= lat_q;
                rx_ipv4_ip <= src_q;
            end
            if (err_ev && rx_err_count != 16'hFFFF) rx_err_count <= rx_err_count + 16'd1;
            if (is_start) begin
                state_q <= HDR;
                idx_q   <= 3'd1;
                wcnt_q  <= 13'd1;
                mis_q   <= 1'b0;
            end else if (in_frame && (term || abort)) begin
                state_q <= IDLE;
            end else if (in_frame) begin
                wcnt_q <= wcnt_q == 13'h1FFF ? wcnt_q : wcnt_q + 13'd1;
                if (state_q == HDR) begin
                    idx_q <= idx_q + 3'd1;
                    mis_q <= mis_q | word_bad;
                    if (idx_q == 3'd4) src_q <= mid32;
                    if (idx_q == 3'd6) ts_hi_q <= hi16;
                    if (idx_q == 3'd7) begin
                        lat_q   <= lat_d;
                        state_q <= PAYLOAD;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_probe_rx.sv
// tb_probe_rx: scoreboard bench for probe_rx with a per-second rate model.
module tb_probe_rx;
    localparam logic [31:0] IP    = 32'h0A001569;
    localparam logic [31:0] MAGIC = 32'h5EC0DE42;
    localparam int          SEC   = 100;
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] gc = 32'd0;
    logic [63:0] rxd = IDLE_W;
    logic [7:0]  rxc = 8'hFF;
    logic [31:0] rx_pps, rx_throughput, rx_ipv4_ip;
    logic [23:0] rx_latency;
    logic [15:0] rx_err_count;
    probe_rx #(.Int_ipv4_addr(IP), .Magic_code(MAGIC), .Sec_cycles(28'(SEC))) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .global_counter(gc),
        .xgmii_rxd(rxd), .xgmii_rxc(rxc),
        .rx_pps(rx_pps), .rx_throughput(rx_throughput), .rx_latency(rx_latency),
        .rx_ipv4_ip(rx_ipv4_ip), .rx_err_count(rx_err_count)
    );
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_pass = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    // Second/rate model: driven by the bench's own knowledge of when a matched frame ends.
    int          msec;
    bit          tick_chk;
    bit          mev = 1'b0;
    logic [31:0] mev_bytes = 32'd0;
    logic [31:0] macc, mbytes, mpps, mthr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msec = SEC; tick_chk = 1'b0; macc = 0; mbytes = 0; mpps = 0; mthr = 0;
        end else begin
            tick_chk = msec == 0;
            msec = tick_chk ? SEC : msec - 1;
            if (tick_chk) begin
                mpps = macc; mthr = mbytes;
                macc = mev ? 32'd1 : 32'd0; mbytes = mev ? mev_bytes : 32'd0;
            end else if (mev) begin
                macc = macc + 1; mbytes = mbytes + mev_bytes;
            end
        end
    end
    always @(negedge clk) if (rst_n && tick_chk) begin
        check("tick_pps", rx_pps, mpps);
        check("tick_thr", rx_throughput, mthr);
    end
    typedef struct {logic [23:0] lat; logic [31:0] ip; logic [15:0] err;} exp_t;
    exp_t sbq[$];
    logic [23:0] e_lat = 0;
    logic [31:0] e_ip = 0;
    logic [15:0] e_err = 0;
    task automatic drive(input logic [63:0] d, input logic [7:0] c, input bit ev, input logic [31:0] evb);
        @(negedge clk);
        rxd = d; rxc = c; mev = ev; mev_bytes = evb;
    endtask
    task automatic send_frame(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] magic,
                              input logic [7:0] proto, input logic [31:0] ts, input logic [31:0] dgc,
                              input int t, input int l, input int cut, input int fe_at, input bit bad_start);
        logic [63:0] w [0:15];
        logic [7:0]  c [0:15];
        logic [31:0] d, nb;
        bit          good;
        exp_t        e;
        int          n;
        good = dst == IP && magic == MAGIC && proto == 8'h11 && t >= 8 && cut < 0 && fe_at < 0 && !bad_start;
        nb = 32'(8*t + l - 8);
        for (int i = 0; i <= t; i++) begin
            w[i] = {$urandom, $urandom};
            c[i] = 8'h00;
        end
        w[0] = 64'hD5555555555555FB; c[0] = 8'h01;
        if (bad_start) begin
            w[0][7:0] = 8'h55; w[0][39:32] = 8'hFB; c[0] = 8'h10;
        end
        w[2][63:32] = 32'h00450008;
        w[3][63:56] = proto;
        w[4][23:16] = src[31:24];   w[4][31:24] = src[23:16];
        w[4][39:32] = src[15:8];    w[4][47:40] = src[7:0];
        w[4][55:48] = dst[31:24];   w[4][63:56] = dst[23:16];
        w[5][7:0]   = dst[15:8];    w[5][15:8]  = dst[7:0];
        w[6][23:16] = magic[31:24]; w[6][31:24] = magic[23:16];
        w[6][39:32] = magic[15:8];  w[6][47:40] = magic[7:0];
        w[6][55:48] = ts[31:24];    w[6][63:56] = ts[23:16];
        w[7][7:0]   = ts[15:8];     w[7][15:8]  = ts[7:0];
        for (int k = l; k < 8; k++) begin
            w[t][8*k +: 8] = (k == l) ? 8'hFD : 8'h07;
            c[t][k] = 1'b1;
        end
        if (fe_at >= 0) begin
            w[fe_at][31:24] = 8'hFE; c[fe_at] = 8'h08;
        end
        if (good) begin
            d = dgc - ts;
            e_lat = d < 32'h01000000 ? d[23:0] : 24'hFFFFFF;
            e_ip = src;
        end
        if (cut < 0 && !bad_start && (fe_at > 0 || t <= 7)) e_err = e_err + 1;
        if (cut < 0) sbq.push_back('{e_lat, e_ip, e_err});
        gc = dgc;
        n = cut >= 0 ? cut : t + 1;
        for (int i = 0; i < n; i++) drive(w[i], c[i], good && i == t, nb);
        if (cut < 0) begin
            drive(IDLE_W, 8'hFF, 1'b0, 32'd0);
            drive(IDLE_W, 8'hFF, 1'b0, 32'd0);
            e = sbq.pop_front();
            check("lat", 32'(rx_latency), 32'(e.lat));
            check("ip", rx_ipv4_ip, e.ip);
            check("err", 32'(rx_err_count), 32'(e.err));
        end
    endtask
    task automatic send_good(input logic [31:0] src, input logic [31:0] ts, input logic [31:0] dgc,
                             input int t, input int l);
        send_frame(src, IP, MAGIC, 8'h11, ts, dgc, t, l, -1, -1, 1'b0);
    endtask
    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (msec != 0 && n < 4*SEC) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4*SEC) check("tick_wait", 32'd0, 32'd1);
        @(negedge clk);
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_pps"}, rx_pps, 32'd0);
        check({tag, "_thr"}, rx_throughput, 32'd0);
        check({tag, "_lat"}, 32'(rx_latency), 32'd0);
        check({tag, "_ip"}, rx_ipv4_ip, 32'd0);
        check({tag, "_err"}, 32'(rx_err_count), 32'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        send_good(32'hC0A80001, 32'd1000, 32'd1250, 9, 0);
        check("lat250", 32'(rx_latency), 32'd250);
        wait_tick();
        check("sec1_pps", rx_pps, 32'd1);
        check("sec1_thr", rx_throughput, 32'd64);
        send_good(32'hC0A80002, 32'd500, 32'd600, 9, 0);
        send_good(32'hC0A80003, 32'd7, 32'd7, 9, 0);
        send_good(32'hC0A80004, 32'd100, 32'd130, 9, 0);
        wait_tick();
        check("three_pps", rx_pps, 32'd3);
        check("three_thr", rx_throughput, 32'd192);
        wait_tick();
        check("empty_pps", rx_pps, 32'd0);
        check("empty_thr", rx_throughput, 32'd0);
        send_frame(32'hC0A800AA, IP, MAGIC ^ 32'd1, 8'h11, 32'd0, 32'd0, 9, 0, -1, -1, 1'b0);
        send_frame(32'hC0A800AB, IP ^ 32'h100, MAGIC, 8'h11, 32'd0, 32'd0, 9, 0, -1, -1, 1'b0);
        send_frame(32'hC0A800AC, IP, MAGIC, 8'h06, 32'd0, 32'd0, 9, 0, -1, -1, 1'b0);
        send_frame(32'hC0A800AD, IP, MAGIC, 8'h11, 32'd0, 32'd0, 9, 0, -1, -1, 1'b1);
        send_good(32'hC0A80005, 32'd2000, 32'd2040, 10, 3);
        wait_tick();
        check("lane3_pps", rx_pps, 32'd1);
        check("lane3_thr", rx_throughput, 32'd75);
        send_frame(32'hC0A800BB, IP, MAGIC, 8'h11, 32'd0, 32'd0, 5, 2, -1, -1, 1'b0);
        check("runt_err", 32'(rx_err_count), 32'd1);
        send_frame(32'hC0A800BC, IP, MAGIC, 8'h11, 32'd0, 32'd0, 9, 0, 4, -1, 1'b0);
        e_err = e_err + 1;
        send_good(32'hC0A80006, 32'd10, 32'd20, 9, 0);
        check("restart_err", 32'(rx_err_count), 32'd2);
        send_frame(32'hC0A800CC, IP, MAGIC, 8'h11, 32'd0, 32'd0, 10, 0, -1, 8, 1'b0);
        send_good(32'hC0A80007, 32'hFFFFFF00, 32'h00000010, 9, 0);
        check("wrap_lat", 32'(rx_latency), 32'h110);
        send_good(32'hC0A80008, 32'd0, 32'h01000005, 9, 0);
        check("sat_lat", 32'(rx_latency), 32'hFFFFFF);
        wait_tick();
        n = 0;
        while (msec != 10 && n < 4*SEC) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4*SEC) check("align_wait", 32'd0, 32'd1);
        send_good(32'hC0A80009, 32'd5, 32'd9, 9, 0);
        check("coin_pps", rx_pps, 32'd0);
        check("coin_thr", rx_throughput, 32'd0);
        wait_tick();
        check("coin_next_pps", rx_pps, 32'd1);
        check("coin_next_thr", rx_throughput, 32'd64);
        send_frame(32'hC0A800DD, IP, MAGIC, 8'h11, 32'd0, 32'd0, 9, 0, 5, -1, 1'b0);
        rst_n = 1'b0;
        e_lat = 0; e_ip = 0; e_err = 0;
        @(negedge clk);
        check_zero("midrst");
        drive(IDLE_W, 8'hFF, 1'b0, 32'd0);
        rst_n = 1'b1;
        send_good(32'hC0A8000A, 32'd40, 32'd50, 9, 0);
        check("post_rst_lat", 32'(rx_latency), 32'd10);
        repeat (3) drive(IDLE_W, 8'hFF, 1'b0, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/probe_rx.md
PROBE_RX -- requirements
Module: probe_rx

Interface
REQ-001 SHALL have parameter Int_ipv4_addr, 32'h0A001569 (10.0.21.105), destination IPv4 address that frames must match.
REQ-002 SHALL have parameter Magic_code, 32'h0, expected probe magic word; the instantiation sets it to the codebase MAGIC_CODE.
REQ-003 SHALL have parameter Sec_cycles, 28'd156250000, sys_clk cycles per measurement second.
REQ-004 sys_clk  input  1  single clock; all logic is on its rising edge.
REQ-005 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-006 global_counter  input  32  free-running timestamp in the sys_clk domain, the same counter the transmitter stamps.
REQ-007 xgmii_rxd  input  64  XGMII receive data; lane n = bits [8n+7:8n], lane 0 is the first byte.
REQ-008 xgmii_rxc  input  8  XGMII receive control, one bit per lane.
REQ-009 rx_pps  output  32  matched frames counted in the last completed second.
REQ-010 rx_throughput  output  32  matched frame bytes counted in the last completed second.
REQ-011 rx_latency  output  24  latency of the last matched frame, in sys_clk cycles.
REQ-012 rx_ipv4_ip  output  32  source IPv4 address of the last matched frame.
REQ-013 rx_err_count  output  16  count of aborted or runt frames; saturates at 16'hFFFF.

Function
REQ-014 SHALL recognise start only as rxc=8'h01 with lane0=8'hFB; a start in any other lane is ignored.
REQ-015 SHALL run the FSM IDLE->HDR on start; HDR->PAYLOAD after word 7; HDR/PAYLOAD->IDLE on terminate.
REQ-016 The start word is word 0. Words 1..7 are counted by a 3-bit index held in HDR.
REQ-017 SHALL check word 2 lanes 4-7 = 08,00,45,00 (ethertype 0x0800, IHL 5).
REQ-018 SHALL check word 3 lane 7 = 8'h11 (UDP).
REQ-019 SHALL check dst IP = Int_ipv4_addr, taken from word 4 lanes 6-7 and word 5 lanes 0-1, big-endian.
REQ-020 SHALL capture src IP from word 4 lanes 2-5, big-endian.
REQ-021 SHALL check magic = Magic_code from word 6 lanes 2-5, big-endian.
REQ-022 SHALL capture timestamp from word 6 lanes 6-7 and word 7 lanes 0-1, big-endian.
REQ-023 A single sticky mismatch flag SHALL be set by any failed check; once set, the frame is not counted as matched.
REQ-024 In the word-7 cycle: diff = global_counter - timestamp, modulo 2^32. Latency = diff[23:0] if diff < 2^24, else 24'hFFFFFF.
REQ-025 Terminate = any lane with rxc bit set and data 8'hFD. Frame bytes = 8*(word index) + lane(FD) - 8, covering dst MAC through FCS.
REQ-026 A frame is matched if terminate arrives in PAYLOAD state and the mismatch flag is clear.
REQ-027 On the cycle after terminate of a matched frame: rx_latency and rx_ipv4_ip update; the pps accumulator gets +1; the byte accumulator gets +bytes.
REQ-028 Terminate in HDR (runt), a start while in HDR/PAYLOAD, or any lane = 8'hFE with rxc set while in a frame SHALL increment rx_err_count and discard the frame.
REQ-029 A start received while in a frame SHALL be accepted as a new frame in the same cycle.
REQ-030 Accumulators SHALL be 32-bit and saturate at 32'hFFFFFFFF.
REQ-031 The second counter SHALL load Sec_cycles and decrement; reaching 0 asserts tick for one cycle and reloads.
REQ-032 On tick, rx_pps and rx_throughput SHALL take the accumulator values and the accumulators SHALL clear.
REQ-033 If a matched-frame update coincides with tick, that frame SHALL be credited to the new second: accumulators load 1 and the frame's byte count.
REQ-034 Idle (8'h07) and other control characters outside a frame SHALL be ignored.

Reset
REQ-035 On sys_rst_n low, all outputs and accumulators SHALL asynchronously go to 0, the FSM to IDLE, and the second counter to Sec_cycles.
REQ-036 Reset asserted mid-frame SHALL discard the frame without any error count.
REQ-037 After deassertion, the first valid start SHALL be accepted.

Verification
REQ-038 One matched 64-byte frame (FD in lane 0 of word 9) with timestamp 1000, arriving at global_counter 1250 -> rx_latency=250, pps accumulator=1, bytes=64.
REQ-039 Sec_cycles=100, 3 matched 64-byte frames in one second -> at tick rx_pps=3, rx_throughput=192; next second with no traffic -> 0, 0.
REQ-040 Wrong magic, wrong dst IP, and proto=6, one frame each -> no pps change, rx_err_count unchanged.
REQ-041 Terminate in word 5 -> rx_err_count=1; start at word 4 of a frame -> rx_err_count+1 and the second frame counted normally.
REQ-042 Timestamp 32'hFFFFFF00 with global_counter 32'h00000010 -> rx_latency=0x110; a diff of 2^24+5 -> 24'hFFFFFF.
REQ-043 Matched-frame completion in the same cycle as tick -> rx_pps excludes it, and the new accumulator=1.
